counter_updown_mod: RTL and testbench
=====================================

// Module: counter_updown_mod
// PURPOSE
//   Parametrised modulo-N up/down counter. Next generation of the 4-bit free-running counter.
//   Adds width/modulus parameters, count enable, parallel load, direction control and
//   wrap / saturate / one-shot modes. Provides a terminal-count pulse for chaining and
//   timer use in downstream datapath and display blocks.
// PARAMETERS
//   WIDTH    8           counter width in bits (>=2)
//   MODULUS  2**WIDTH    count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH
//   (derived) MAX = MODULUS-1
// PORTS
//   clk       in   1      clock, all state updates on rising edge
//   reset     in   1      synchronous, active-high reset
//   en        in   1      count enable; a step happens only when en=1
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  load value; values >MAX are clamped to MAX
//   up        in   1      direction: 1=increment, 0=decrement
//   mode      in   2      00=WRAP, 01=SAT, 10=ONESHOT, 11=reserved (behaves as WRAP)
//   start     in   1      ONESHOT only: arm and start a run
//   count     out  WIDTH  registered count value
//   tc        out  1      registered terminal-count pulse, exactly 1 cycle
//   at_max    out  1      comb: count==MAX
//   at_min    out  1      comb: count==0
//   busy      out  1      registered: 1 while ONESHOT FSM is in RUN
// BEHAVIOUR
//   Reset: count=0, tc=0, busy=0, FSM=IDLE. Reset wins over every other input.
//   Priority below reset: load > start > count step. Inputs sampled at rising clk; 1-cycle latency.
//   Terminal value T = MAX when up=1, 0 when up=0 (evaluated in the cycle of the step).
//   tc=1 in the cycle after a count step writes T into count, i.e. coincident with count==T.
//     A step that does not write T gives tc=0. Load never raises tc, even if load_val==T.
//     Holding at T gives tc=0.
//   load: count<=min(load_val,MAX); FSM<=IDLE; tc<=0.
//   WRAP: en=1 steps +-1 modulo MODULUS (up: MAX->0; down: 0->MAX).
//   SAT: en=1 steps +-1. At T the counter holds. tc pulses once, on entry to T.
//   ONESHOT FSM:
//     IDLE: count holds. start=1 -> count<=(up?0:MAX), go to RUN; no tc.
//     RUN: en=1 steps toward T. The step that writes T raises tc and moves to DONE.
//       en=0 pauses the run.
//     DONE: count holds at T.
//       start=1 -> count<=(up?0:MAX), go to RUN (restart).
//     start while in RUN is ignored.
//     busy = (FSM==RUN).
//     A direction change mid-run re-targets T immediately.
//       Example: reversing at count=0 with up=0 writes nothing new. That cycle holds;
//       T=0 is already reached, so the FSM goes to DONE without tc.
//   mode!=ONESHOT: FSM forced to IDLE, busy=0, start ignored.
//   Mode changes take effect on the next step.
//   MODULUS==2**WIDTH: wrap uses natural overflow; no compare-reset path is required.
//   Arithmetic is done in WIDTH bits; no intermediate value exceeds MAX.
// TESTING (WIDTH=4, MODULUS=10 unless stated)
//   1 reset=1 2 cycles with en=1,load=1 -> count=0,tc=0,busy=0. Release, WRAP,up,en=1 ->
//     0,1..9 (tc=1 only at 9), then 0,1; at_max=1 only at 9.
//   2 WRAP down: load_val=2, then up=0,en=1 -> 1,0(tc=1),9,8; en=0 holds 8 with tc=0.
//   3 SAT up: load_val=7, en=1 -> 8,9(tc=1),9,9 (tc=0). Then up=0 -> 8..0 (tc at 0), holds 0.
//   4 ONESHOT up: start=1 -> count=0, busy=1; en=1 -> 1..9 (tc at 9), busy=0, holds 9.
//     start in RUN ignored. start in DONE restarts at 0.
//   5 load_val=15 -> count=9, tc=0. load+start same cycle -> load wins, FSM=IDLE.
//     reset mid-ONESHOT at count=5 -> next cycle count=0, busy=0.
//   6 WIDTH=4,MODULUS=16 WRAP up from 14 -> 15(tc),0,1; down from 0 -> 15,14.

Source files
------------

// File: rtl/counter_updown_mod.sv
// Modulo-N up/down counter with load, enable, direction and WRAP / SAT / ONESHOT modes.
// Emits a one-cycle terminal-count pulse for chaining and timer use.
module counter_updown_mod #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 2**WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_min,
    output logic             busy,
    output logic [1:0]       fsm_state
);

    localparam logic [WIDTH-1:0] MAX          = WIDTH'(MODULUS - 1);
    localparam logic [1:0]       MODE_SAT     = 2'b01;
    localparam logic [1:0]       MODE_ONESHOT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             busy_q;

    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] step_d;
    logic [WIDTH-1:0] target;
    logic             at_target;
    logic             step_hits;
    logic [WIDTH-1:0] restart_val;

    // Terminal value follows the current direction, so a reversal re-targets at once.
    always_comb begin
        load_clamped = (load_val > MAX) ? MAX : load_val;
        inc_val      = (count_q == MAX) ? '0 : count_q + WIDTH'(1);
        dec_val      = (count_q == '0) ? MAX : count_q - WIDTH'(1);
        step_d       = up ? inc_val : dec_val;
        target       = up ? MAX : '0;
        restart_val  = up ? '0 : MAX;
        at_target    = (count_q == target);
        step_hits    = (step_d == target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else if (load) begin
            count_q <= load_clamped;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
        end else if (mode == MODE_ONESHOT) begin
            tc_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (en) begin
                        if (at_target) begin
                            // Already sitting on the (re-targeted) terminal: finish silently.
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else begin
                            count_q <= step_d;
                            if (step_hits) begin
                                tc_q    <= 1'b1;
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        count_q <= restart_val;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            tc_q    <= 1'b0;
            // SAT parks on the terminal value; WRAP and the reserved mode always move.
            if (en && !((mode == MODE_SAT) && at_target)) begin
                count_q <= step_d;
                tc_q    <= step_hits;
            end
        end
    end

    assign count     = count_q;
    assign tc        = tc_q;
    assign busy      = busy_q;
    assign at_max    = (count_q == MAX);
    assign at_min    = (count_q == '0);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: two counters (modulus 10 and 16) share stimulus; an arithmetic
// model predicts every cycle, a monitor compares against the queued predictions.
module tb_counter_updown_mod;

  logic       clk = 1'b0;
  logic       reset, en, load, up, start;
  logic [3:0] load_val;
  logic [1:0] mode;

  logic [3:0] count_a, count_b;
  logic       tc_a, tc_b, at_max_a, at_max_b, at_min_a, at_min_b, busy_a, busy_b;
  logic [1:0] st_a, st_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  int m_cnt[2];
  bit m_tc[2];
  bit m_run[2];

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .up(up),
    .mode(mode), .start(start), .count(count_a), .tc(tc_a), .at_max(at_max_a),
    .at_min(at_min_a), .busy(busy_a), .fsm_state(st_a)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .up(up),
    .mode(mode), .start(start), .count(count_b), .tc(tc_b), .at_max(at_max_b),
    .at_min(at_min_b), .busy(busy_b), .fsm_state(st_b)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack_exp(input int i);
    int m;
    m = (i == 0) ? 10 : 16;
    return {4'(m_cnt[i]), m_tc[i], m_run[i], m_cnt[i] == m - 1, m_cnt[i] == 0};
  endfunction

  // Reference behaviour: plain integer arithmetic, one "running" flag per counter.
  task automatic model_step();
    int m;
    int tgt;
    for (int i = 0; i < 2; i++) begin
      m   = (i == 0) ? 10 : 16;
      tgt = up ? m - 1 : 0;
      if (reset) begin
        m_cnt[i] = 0; m_tc[i] = 0; m_run[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > m - 1) ? m - 1 : int'(load_val);
        m_tc[i] = 0; m_run[i] = 0;
      end else if (mode == 2'b10) begin
        m_tc[i] = 0;
        if (!m_run[i]) begin
          if (start) begin
            m_cnt[i] = up ? 0 : m - 1;
            m_run[i] = 1;
          end
        end else if (en) begin
          if (m_cnt[i] == tgt) begin
            m_run[i] = 0;
          end else begin
            m_cnt[i] = m_cnt[i] + (up ? 1 : -1);
            if (m_cnt[i] == tgt) begin
              m_tc[i] = 1; m_run[i] = 0;
            end
          end
        end
      end else begin
        m_run[i] = 0; m_tc[i] = 0;
        if (en && !(mode == 2'b01 && m_cnt[i] == tgt)) begin
          m_cnt[i] = (m_cnt[i] + (up ? 1 : m - 1)) % m;
          m_tc[i]  = (m_cnt[i] == tgt);
        end
      end
    end
    exp_q.push_back({pack_exp(0), pack_exp(1)});
  endtask

  task automatic cyc(input logic r_in, input logic ld_in, input logic [3:0] lv_in,
                     input logic up_in, input logic [1:0] m_in, input logic en_in,
                     input logic st_in);
    reset = r_in; load = ld_in; load_val = lv_in; up = up_in;
    mode = m_in; en = en_in; start = st_in;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cyc_n(input int n, input logic up_in, input logic [1:0] m_in,
                       input logic en_in, input logic st_in);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 4'd0, up_in, m_in, en_in, st_in);
  endtask

  // Monitor: one registered result per clock, compared 1 time unit after the edge.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count_m10",  {4'd0, count_a},  {4'd0, e[15:12]});
        check("tc_m10",     {7'd0, tc_a},     {7'd0, e[11]});
        check("busy_m10",   {7'd0, busy_a},   {7'd0, e[10]});
        check("at_max_m10", {7'd0, at_max_a}, {7'd0, e[9]});
        check("at_min_m10", {7'd0, at_min_a}, {7'd0, e[8]});
        check("count_m16",  {4'd0, count_b},  {4'd0, e[7:4]});
        check("tc_m16",     {7'd0, tc_b},     {7'd0, e[3]});
        check("busy_m16",   {7'd0, busy_b},   {7'd0, e[2]});
        check("at_max_m16", {7'd0, at_max_b}, {7'd0, e[1]});
        check("at_min_m16", {7'd0, at_min_b}, {7'd0, e[0]});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r_up;
    logic [1:0] r_mode;
    reset = 1'b1; load = 1'b0; load_val = '0; up = 1'b1; mode = 2'b00; en = 1'b0; start = 1'b0;
    r_up = 1'b1; r_mode = 2'b00;
    @(negedge clk);

    // Reset dominates load and enable; then WRAP up through the full range.
    cyc(1'b1, 1'b1, 4'd7, 1'b1, 2'b00, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 4'd7, 1'b1, 2'b00, 1'b1, 1'b0);
    cyc_n(12, 1'b1, 2'b00, 1'b1, 1'b0);

    // WRAP down across zero, then pause.
    cyc(1'b0, 1'b1, 4'd2, 1'b1, 2'b00, 1'b0, 1'b0);
    cyc_n(4, 1'b0, 2'b00, 1'b1, 1'b0);
    cyc_n(2, 1'b0, 2'b00, 1'b0, 1'b0);

    // SAT up into the top, hold, then down into zero and hold.
    cyc(1'b0, 1'b1, 4'd7, 1'b1, 2'b01, 1'b1, 1'b0);
    cyc_n(4, 1'b1, 2'b01, 1'b1, 1'b0);
    cyc_n(18, 1'b0, 2'b01, 1'b1, 1'b0);

    // ONESHOT up: start, ignored start mid-run, finish, hold, restart from DONE.
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'b10, 1'b0, 1'b1);
    cyc_n(4, 1'b1, 2'b10, 1'b1, 1'b0);
    cyc_n(2, 1'b1, 2'b10, 1'b1, 1'b1);
    cyc_n(2, 1'b1, 2'b10, 1'b0, 1'b0);
    cyc_n(12, 1'b1, 2'b10, 1'b1, 1'b0);
    cyc_n(2, 1'b1, 2'b10, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'b10, 1'b1, 1'b1);
    cyc_n(3, 1'b1, 2'b10, 1'b1, 1'b0);
    // Mid-run reversal heads back to zero; reversal at zero finishes without tc.
    cyc_n(4, 1'b0, 2'b10, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'b10, 1'b0, 1'b1);
    cyc_n(2, 1'b0, 2'b10, 1'b1, 1'b0);
    // ONESHOT down run.
    cyc(1'b0, 1'b0, 4'd0, 1'b0, 2'b10, 1'b1, 1'b1);
    cyc_n(17, 1'b0, 2'b10, 1'b1, 1'b0);

    // Load clamp, load beats start, reset mid-run.
    cyc(1'b0, 1'b1, 4'd15, 1'b1, 2'b00, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 4'd9, 1'b1, 2'b10, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 4'd3, 1'b1, 2'b10, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'b10, 1'b0, 1'b1);
    cyc_n(5, 1'b1, 2'b10, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 4'd0, 1'b1, 2'b10, 1'b1, 1'b0);
    cyc_n(1, 1'b1, 2'b10, 1'b0, 1'b0);

    // Full-range wrap on the modulus-16 counter (and clamped on modulus 10).
    cyc(1'b0, 1'b1, 4'd14, 1'b1, 2'b00, 1'b0, 1'b0);
    cyc_n(3, 1'b1, 2'b00, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0);
    cyc_n(2, 1'b0, 2'b00, 1'b1, 1'b0);
    // Reserved mode behaves as WRAP.
    cyc_n(3, 1'b1, 2'b11, 1'b1, 1'b0);

    // Randomized traffic with sticky direction and mode.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) r_up = ~r_up;
      if ($urandom_range(0, 15) == 0) r_mode = 2'($urandom_range(0, 3));
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
          4'($urandom_range(0, 15)), r_up, r_mode,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
    end

    @(posedge clk);
    #2;
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
